// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: address split, mode encoding
// and the slave_port state encoding.
package bus_pkg;

  localparam int BUS_ADDR_WIDTH          = 16;
  localparam int SLAVE_DEVICE_ADDR_WIDTH = 4;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } bus_mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    REQ   = 3'd3,
    RWAIT = 3'd4,
    RDATA = 3'd5
  } sp_state_e;

endpackage

// File: rtl/sipo_shift.sv
// Bit-indexed serial-in/parallel-out register: writes one bit at idx_i per
// load, with a synchronous clear that a same-cycle load overrides bit-wise.
module sipo_shift #(
  parameter int WIDTH = 8,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;

  // NOTE: sequential state uses <= only; the later bit write deliberately
  // wins over the clear when both happen in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '0;
    end else begin
      if (clr_i)  data_q        <= '0;
      if (load_i) data_q[idx_i] <= bit_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/slave_port.sv
// Serial bus slave endpoint: deserialises address/write data, issues one
// ready/valid device request, and serialises read data back LSB-first.
module slave_port
  import bus_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = BUS_ADDR_WIDTH - SLAVE_DEVICE_ADDR_WIDTH,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      swdata,
  input  logic                      smode,
  input  logic                      svalid_in,
  output logic                      srdata,
  output logic                      svalid,
  output logic                      sready,
  output logic [MEM_ADDR_WIDTH-1:0] daddr,
  output logic [DATA_WIDTH-1:0]     dwdata,
  output logic                      dmode,
  output logic                      dvalid,
  input  logic                      dready,
  input  logic [DATA_WIDTH-1:0]     drdata,
  input  logic                      drvalid
);

  localparam int CNT_MAX = (MEM_ADDR_WIDTH > DATA_WIDTH) ? MEM_ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int AIDX_W  = $clog2(MEM_ADDR_WIDTH);
  localparam int DIDX_W  = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(MEM_ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  sp_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  bus_mode_e             mode_q, mode_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  dvalid_q, dvalid_d;
  logic                  svalid_q, svalid_d;
  logic                  srdata_q, srdata_d;
  logic                  capt_clr, addr_ld, wdata_ld;

  sipo_shift #(.WIDTH(MEM_ADDR_WIDTH), .IDX_W(AIDX_W)) u_addr_sipo (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (capt_clr),
    .load_i (addr_ld),
    .idx_i  (cnt_q[AIDX_W-1:0]),
    .bit_i  (swdata),
    .data_o (daddr)
  );

  sipo_shift #(.WIDTH(DATA_WIDTH), .IDX_W(DIDX_W)) u_wdata_sipo (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (capt_clr),
    .load_i (wdata_ld),
    .idx_i  (cnt_q[DIDX_W-1:0]),
    .bit_i  (swdata),
    .data_o (dwdata)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    rdata_d  = rdata_q;
    dvalid_d = dvalid_q;
    svalid_d = 1'b0;
    srdata_d = 1'b0;
    capt_clr = 1'b0;
    addr_ld  = 1'b0;
    wdata_ld = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (svalid_in) begin
          capt_clr = 1'b1;
          addr_ld  = 1'b1;
          mode_d   = bus_mode_e'(smode);
          cnt_d    = CNT_W'(1);
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (svalid_in) begin
          addr_ld = 1'b1;
          if (cnt_q == ADDR_LAST) begin
            cnt_d = '0;
            if (mode_q == WRITE) begin
              state_d = WDATA;
            end else begin
              state_d  = REQ;
              dvalid_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WDATA: begin
        if (svalid_in) begin
          wdata_ld = 1'b1;
          if (cnt_q == DATA_LAST) begin
            cnt_d    = '0;
            state_d  = REQ;
            dvalid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      REQ: begin
        if (dready) begin
          dvalid_d = 1'b0;
          state_d  = (mode_q == WRITE) ? IDLE : RWAIT;
        end
      end
      RWAIT: begin
        if (drvalid) begin
          rdata_d  = drdata;
          cnt_d    = '0;
          svalid_d = 1'b1;
          srdata_d = drdata[0];
          state_d  = RDATA;
        end
      end
      RDATA: begin
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          svalid_d = 1'b1;
          srdata_d = rdata_q[cnt_d[DIDX_W-1:0]];
        end
      end
      default: begin
        cnt_d    = '0;
        dvalid_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mode_q   <= READ;
      rdata_q  <= '0;
      dvalid_q <= 1'b0;
      svalid_q <= 1'b0;
      srdata_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      rdata_q  <= rdata_d;
      dvalid_q <= dvalid_d;
      svalid_q <= svalid_d;
      srdata_q <= srdata_d;
    end
  end

  assign sready = (state_q == IDLE);
  assign dmode  = mode_q;
  assign dvalid = dvalid_q;
  assign svalid = svalid_q;
  assign srdata = srdata_q;

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port: writes, reads, gapped input, backpressure,
// reset during read-out and ignored-input robustness.
module tb_slave_port;

  logic        clk;
  logic        rstn;
  logic        swdata;
  logic        smode;
  logic        svalid_in;
  logic        srdata;
  logic        svalid;
  logic        sready;
  logic [11:0] daddr;
  logic [7:0]  dwdata;
  logic        dmode;
  logic        dvalid;
  logic        dready;
  logic [7:0]  drdata;
  logic        drvalid;

  int n_total = 0;
  int n_bad   = 0;
  int hs_cnt  = 0;

  slave_port dut (
    .clk       (clk),
    .rstn      (rstn),
    .swdata    (swdata),
    .smode     (smode),
    .svalid_in (svalid_in),
    .srdata    (srdata),
    .svalid    (svalid),
    .sready    (sready),
    .daddr     (daddr),
    .dwdata    (dwdata),
    .dmode     (dmode),
    .dvalid    (dvalid),
    .dready    (dready),
    .drdata    (drdata),
    .drvalid   (drvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge, so they are stable here.
  always @(negedge clk) if (dvalid && dready) hs_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift n bits LSB-first; with gap, an idle cycle (with a decoy data bit)
  // precedes every bit except the very first of a transaction.
  task automatic shift_bits(input logic [15:0] val, input int n, input bit gap, input bit first);
    for (int i = 0; i < n; i++) begin
      if (gap && !(first && i == 0)) begin
        svalid_in = 1'b0;
        swdata    = ~val[i];
        tick();
      end
      swdata    = val[i];
      svalid_in = 1'b1;
      tick();
      svalid_in = 1'b0;
    end
  endtask

  task automatic expect_serial(input string tag, input logic [7:0] word);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_svalid%0d", tag, i), 32'(svalid), 32'd1);
      check($sformatf("%s_bit%0d", tag, i), 32'(srdata), 32'(word[i]));
      tick();
    end
    check({tag, "_svalid_end"}, 32'(svalid), 32'd0);
    check({tag, "_sready_end"}, 32'(sready), 32'd1);
  endtask

  task automatic expect_req(input string tag, input logic [11:0] a, input logic [7:0] d,
                            input logic m);
    check({tag, "_dvalid"}, 32'(dvalid), 32'd1);
    check({tag, "_daddr"}, 32'(daddr), 32'(a));
    if (m) check({tag, "_dwdata"}, 32'(dwdata), 32'(d));
    check({tag, "_dmode"}, 32'(dmode), 32'(m));
    check({tag, "_sready"}, 32'(sready), 32'd0);
  endtask

  initial begin
    int hs0;
    rstn      = 1'b0;
    swdata    = 1'b0;
    smode     = 1'b0;
    svalid_in = 1'b0;
    dready    = 1'b0;
    drdata    = 8'h00;
    drvalid   = 1'b0;
    #12;
    check("rst_sready", 32'(sready), 32'd1);
    check("rst_svalid", 32'(svalid), 32'd0);
    check("rst_srdata", 32'(srdata), 32'd0);
    check("rst_dvalid", 32'(dvalid), 32'd0);
    check("rst_daddr", 32'(daddr), 32'd0);
    check("rst_dwdata", 32'(dwdata), 32'd0);
    check("rst_dmode", 32'(dmode), 32'd0);
    rstn = 1'b1;
    tick();

    // Write, no gaps
    smode = 1'b1;
    shift_bits(16'h03C1, 12, 1'b0, 1'b1);
    check("w1_sready_mid", 32'(sready), 32'd0);
    check("w1_dvalid_early", 32'(dvalid), 32'd0);
    shift_bits(16'h00A5, 8, 1'b0, 1'b0);
    expect_req("w1", 12'h3C1, 8'hA5, 1'b1);
    dready = 1'b1;
    tick();
    check("w1_dvalid_after", 32'(dvalid), 32'd0);
    check("w1_idle", 32'(sready), 32'd1);

    // Read, back-to-back in the first IDLE cycle, dready already high
    smode = 1'b0;
    shift_bits(16'h0012, 12, 1'b0, 1'b1);
    expect_req("r1", 12'h012, 8'h00, 1'b0);
    tick();
    check("r1_dvalid_drop", 32'(dvalid), 32'd0);
    check("r1_rwait_sready", 32'(sready), 32'd0);
    tick();
    tick();
    check("r1_svalid_wait", 32'(svalid), 32'd0);
    drdata  = 8'h5A;
    drvalid = 1'b1;
    tick();
    drvalid = 1'b0;
    drdata  = 8'h00;
    expect_serial("r1", 8'h5A);

    // Gapped write
    smode = 1'b1;
    shift_bits(16'h0800, 12, 1'b1, 1'b1);
    shift_bits(16'h00FF, 8, 1'b1, 1'b0);
    expect_req("gap", 12'h800, 8'hFF, 1'b1);
    tick();
    check("gap_done", 32'(sready), 32'd1);

    // Backpressure
    dready = 1'b0;
    smode  = 1'b1;
    shift_bits(16'h0555, 12, 1'b0, 1'b1);
    shift_bits(16'h003C, 8, 1'b0, 1'b0);
    hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      expect_req($sformatf("bp%0d", i), 12'h555, 8'h3C, 1'b1);
      tick();
    end
    dready = 1'b1;
    tick();
    dready = 1'b0;
    check("bp_dvalid_drop", 32'(dvalid), 32'd0);
    check("bp_idle", 32'(sready), 32'd1);
    check("bp_handshakes", 32'(hs_cnt - hs0), 32'd1);

    // Reset during RDATA bit 3
    dready = 1'b1;
    smode  = 1'b0;
    shift_bits(16'h00A5, 12, 1'b0, 1'b1);
    tick();
    drdata  = 8'hFF;
    drvalid = 1'b1;
    tick();
    drvalid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("rr_bit3_svalid", 32'(svalid), 32'd1);
    check("rr_bit3", 32'(srdata), 32'd1);
    rstn = 1'b0;
    #1;
    check("rr_svalid", 32'(svalid), 32'd0);
    check("rr_srdata", 32'(srdata), 32'd0);
    check("rr_sready", 32'(sready), 32'd1);
    check("rr_daddr", 32'(daddr), 32'd0);
    #2;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rr_quiet%0d", i), 32'(svalid), 32'd0);
    end
    smode = 1'b1;
    shift_bits(16'h0123, 12, 1'b0, 1'b1);
    shift_bits(16'h007E, 8, 1'b0, 1'b0);
    expect_req("rr_w", 12'h123, 8'h7E, 1'b1);
    tick();
    check("rr_w_drop", 32'(dvalid), 32'd0);
    check("rr_w_idle", 32'(sready), 32'd1);

    // Ignored inputs: drvalid in IDLE/ADDR, svalid_in in RWAIT, smode after bit 0
    smode   = 1'b0;
    drdata  = 8'hEE;
    drvalid = 1'b1;
    swdata    = 1'b0;
    svalid_in = 1'b1;
    tick();
    smode = 1'b1;
    shift_bits(16'h0456 >> 1, 11, 1'b0, 1'b0);
    drvalid = 1'b0;
    drdata  = 8'h00;
    expect_req("ig", 12'h456, 8'h00, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      swdata    = 1'b1;
      svalid_in = (i != 1);
      tick();
      check($sformatf("ig_rwait_sready%0d", i), 32'(sready), 32'd0);
      check($sformatf("ig_rwait_svalid%0d", i), 32'(svalid), 32'd0);
    end
    svalid_in = 1'b0;
    check("ig_daddr_hold", 32'(daddr), 32'h456);
    check("ig_dmode_hold", 32'(dmode), 32'd0);
    drdata  = 8'h96;
    drvalid = 1'b1;
    tick();
    drvalid = 1'b0;
    expect_serial("ig", 8'h96);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/slave_port.md
# slave_port

Bus-side endpoint for one slave device on the serial system bus. It deserialises the memory address and, for writes, the write data that a master port shifts out LSB-first. It then issues a single parallel ready/valid transaction to the attached slave device and, for reads, serialises the returned data word back onto the bus. It sits downstream of the address decoder, which forwards the selected master's serial traffic only after it has acknowledged the slave device address.

## Interface
- MEM_ADDR_WIDTH, 12, slave memory address bits received per transaction (bus ADDR_WIDTH 16 minus 4 device-select bits)
- DATA_WIDTH, 8, data word width

- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset; asynchronous and active-low
- swdata  in  1  serial address/write data from the bus, LSB first
- smode  in  1  0 = read, 1 = write; valid while svalid_in is high
- svalid_in  in  1  swdata valid strobe, one bit per high cycle
- srdata  out  1  serial read data to the bus, LSB first
- svalid  out  1  srdata valid strobe
- sready  out  1  high in IDLE: port can accept a new transaction
- daddr  out  MEM_ADDR_WIDTH  device address
- dwdata  out  DATA_WIDTH  device write data
- dmode  out  1  device transaction type
- dvalid  out  1  device request valid
- dready  in  1  device accepts the request
- drdata  in  DATA_WIDTH  device read data
- drvalid  in  1  device read data valid

## Operation
- States:
  - IDLE: no transaction in progress.
  - ADDR: receiving address bits.
  - WDATA: receiving write data bits.
  - REQ: device request outstanding.
  - RWAIT: waiting for device read data.
  - RDATA: shifting read data out to the bus.
- IDLE: a cycle with svalid_in=1 latches smode and stores swdata as address bit 0; the bit counter becomes 1 and the state goes to ADDR.
- ADDR: each cycle with svalid_in=1 stores swdata into address bit [counter] and increments the counter.
  - When bit MEM_ADDR_WIDTH-1 is stored, the counter clears.
  - Next state is WDATA if the latched mode is 1, otherwise REQ.
- WDATA: each cycle with svalid_in=1 stores swdata into write data bit [counter]; after bit DATA_WIDTH-1, the state goes to REQ.
- Cycles with svalid_in=0 in ADDR or WDATA hold the counter and all registers; gaps are legal.
- REQ:
  - dvalid=1; daddr, dwdata and dmode are stable and equal to the captured values.
  - Handshake completes on a rising edge with dvalid and dready both high.
  - After the handshake, a write goes to IDLE and a read goes to RWAIT.
- RWAIT: the first cycle with drvalid=1 captures drdata and goes to RDATA. drvalid is ignored in every other state.
- RDATA:
  - For exactly DATA_WIDTH consecutive cycles: svalid=1 and srdata = rdata[counter], counter 0..DATA_WIDTH-1.
  - After the last bit, go to IDLE.
- svalid_in is ignored in REQ, RWAIT and RDATA.
- smode is sampled only on the first address bit.

## Timing
- Reset (asynchronous, rstn=0):
  - State goes to IDLE and the counter clears.
  - All outputs go to 0 except sready, which is 1.
  - Captured registers clear.
  - Reset mid-transaction abandons it; no partial device request is issued.
- All outputs are registered, except sready, which is decoded from state.
- Write latency: the last serial data bit is sampled on edge N; dvalid is high from cycle N+1.
- Read latency:
  - The last address bit is sampled on edge N; dvalid is high from cycle N+1.
  - drvalid is sampled on edge M; svalid and srdata bit 0 appear in cycle M+1.
  - Bit DATA_WIDTH-1 appears in cycle M+DATA_WIDTH; svalid is 0 in cycle M+DATA_WIDTH+1.
- dvalid, once raised, stays high with stable payload until the handshake edge, then drops in the next cycle.
- If dready is already high when dvalid rises, the transfer takes one cycle.
- The device must assert drvalid no earlier than the cycle after the request handshake.
- Back-to-back transactions: the first svalid_in of the next transaction is accepted in the first IDLE cycle.

## Structure
- Shared package bus_pkg contains:
  - SLAVE_DEVICE_ADDR_WIDTH = 4.
  - Bus mode encoding: READ = 0, WRITE = 1.
  - The slave_port state encoding (3 bits).
- One sub-module is natural: sipo_shift, a parameterised bit-indexed serial-in/parallel-out register with load enable and clear, used for both address and write-data capture.
- Read serialisation stays inline.

## Test plan
- Write, no gaps: shift address 0x3C1 then data 0xA5 with svalid_in continuous and smode=1 -> dvalid=1 with daddr=0x3C1, dwdata=0xA5, dmode=1 in the cycle after the last bit; IDLE after the dready handshake.
- Read: address 0x012 with smode=0; dready=1; drvalid with drdata=0x5A three cycles later -> svalid high for 8 consecutive cycles, srdata = 0,1,0,1,1,0,1,0.
- Gapped serial input: write 0xFF to 0x800 with svalid_in low on every other cycle -> identical device request to the no-gap case.
- Backpressure: hold dready=0 for 5 cycles during a write -> dvalid and payload stable all 5 cycles; exactly one handshake.
- Reset mid-read: assert rstn=0 during RDATA bit 3 -> svalid=0 and sready=1 immediately; no further bits; a new write completes correctly afterwards.
- Ignored inputs: toggle svalid_in during RWAIT and drvalid during ADDR -> no state or data corruption; read returns the correct word.
